// File: rtl/imem_loader_if.sv
`default_nettype none
// =============================================================================
// imem_loader_if : boot byte stream, instruction-memory write port, boot status
// Revision: 1.0
// =============================================================================
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic        err;
  logic        core_rst_n;

  // master: stream source / boot controller side
  modport master (
    output in_valid, in_data, restart,
    input  in_ready, wr_en, wr_addr, wr_data, done, err, core_rst_n
  );

  // slave: the loader itself
  modport slave (
    input  in_valid, in_data, restart,
    output in_ready, wr_en, wr_addr, wr_data, done, err, core_rst_n
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// imem_loader : assembles a little-endian boot stream into words for the IMEM
// Revision: 1.0
// =============================================================================
module imem_loader #(
  parameter int unsigned ROM_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [31:0] C_ROM_SIZE = 32'(ROM_SIZE);

  state_e      state_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
  logic [31:0] n_q;
  logic [31:0] idx_q;
  logic        in_ready_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic        done_q;
  logic        err_q;
  logic        core_rst_n_q;

  logic        w_accept;
  logic [31:0] w_word;
  logic        w_last_byte;

  // Only the three older bytes are stored; the newest byte completes the word.
  assign w_accept    = bus.in_valid & in_ready_q;
  assign w_word      = {bus.in_data, shift_q};
  assign w_last_byte = (byte_cnt_q == 2'd3);

  assign bus.in_ready   = in_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.core_rst_n = core_rst_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HDR;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      n_q          <= 32'd0;
      idx_q        <= 32'd0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_HDR: begin
          in_ready_q <= 1'b1;
          if (w_accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= w_word[31:8];
            if (w_last_byte) begin
              if (w_word == 32'd0) begin
                state_q      <= ST_DONE;
                in_ready_q   <= 1'b0;
                done_q       <= 1'b1;
                core_rst_n_q <= 1'b1;
              end else if (w_word > C_ROM_SIZE) begin
                state_q    <= ST_ERR;
                in_ready_q <= 1'b0;
                err_q      <= 1'b1;
              end else begin
                state_q <= ST_LOAD;
                n_q     <= w_word;
                idx_q   <= 32'd0;
              end
            end
          end
        end

        ST_LOAD: begin
          if (w_accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= w_word[31:8];
            if (w_last_byte) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= idx_q << 2;
              wr_data_q <= w_word;
              idx_q     <= idx_q + 32'd1;
              if (idx_q + 32'd1 == n_q) begin
                state_q    <= ST_FLUSH;
                in_ready_q <= 1'b0;
              end
            end
          end
        end

        // Final write strobe is on the bus during this cycle.
        ST_FLUSH: begin
          state_q      <= ST_DONE;
          done_q       <= 1'b1;
          core_rst_n_q <= 1'b1;
        end

        ST_DONE, ST_ERR: begin
          if (bus.restart) begin
            state_q      <= ST_HDR;
            byte_cnt_q   <= 2'd0;
            idx_q        <= 32'd0;
            in_ready_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
          end
        end

        default: begin
          state_q    <= ST_HDR;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// =============================================================================
// tb_imem_loader : directed boot streams checked against a byte-count model
// Revision: 1.0
// =============================================================================
module tb_imem_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  imem_loader_if bus ();

  imem_loader #(.ROM_SIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] wlog [$];

  // Model: outputs follow from how many bytes were accepted in this session.
  int          m_cnt     = 0;
  logic [31:0] m_hdr     = '0;
  logic [31:0] m_word    = '0;
  logic [31:0] m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;
  logic        m_ready   = 1'b0;
  logic        m_wr_en   = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_err     = 1'b0;
  logic        m_fin     = 1'b0;
  logic        m_boot    = 1'b1;

  function automatic logic [31:0] f_shift(input logic [7:0] b, input logic [31:0] w);
    return {b, w[31:8]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_hdr <= '0; m_word <= '0; m_wr_addr <= '0; m_wr_data <= '0;
      m_ready <= 1'b0; m_wr_en <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_fin <= 1'b0; m_boot <= 1'b1;
    end else begin
      m_wr_en <= 1'b0;
      if (m_boot) begin
        m_boot  <= 1'b0;
        m_ready <= 1'b1;
      end
      if (m_fin) begin
        m_fin  <= 1'b0;
        m_done <= 1'b1;
      end
      if (bus.restart && (m_done || m_err)) begin
        m_cnt <= 0; m_done <= 1'b0; m_err <= 1'b0; m_ready <= 1'b1;
      end else if (bus.in_valid && m_ready) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt < 4) begin
          m_hdr <= f_shift(bus.in_data, m_hdr);
          if (m_cnt == 3) begin
            if (f_shift(bus.in_data, m_hdr) == 32'd0) begin
              m_ready <= 1'b0; m_done <= 1'b1;
            end else if (f_shift(bus.in_data, m_hdr) > 32'd32) begin
              m_ready <= 1'b0; m_err <= 1'b1;
            end
          end
        end else begin
          m_word <= f_shift(bus.in_data, m_word);
          if (m_cnt % 4 == 3) begin
            m_wr_en   <= 1'b1;
            m_wr_addr <= 32'(m_cnt - 7);
            m_wr_data <= f_shift(bus.in_data, m_word);
            if (32'((m_cnt - 3) / 4) == m_hdr) begin
              m_ready <= 1'b0; m_fin <= 1'b1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.in_ready !== m_ready || bus.wr_en !== m_wr_en || bus.wr_addr !== m_wr_addr ||
        bus.wr_data !== m_wr_data || bus.done !== m_done || bus.err !== m_err ||
        bus.core_rst_n !== m_done) begin
      errors++;
      $display("FAIL cycle t=%0t act rdy=%b we=%b a=%h d=%h done=%b err=%b crst=%b exp rdy=%b we=%b a=%h d=%h done=%b err=%b crst=%b",
               $time, bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.err,
               bus.core_rst_n, m_ready, m_wr_en, m_wr_addr, m_wr_data, m_done, m_err, m_done);
    end
    if (bus.wr_en === 1'b1) wlog.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 4 && bus.in_ready !== 1'b1; t++) begin
      @(posedge clk); #1;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout act rdy=%b exp rdy=1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int g0, input int g1, input int g2, input int g3);
    send_byte(w[7:0], g0);
    send_byte(w[15:8], g1);
    send_byte(w[23:16], g2);
    send_byte(w[31:24], g3);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    @(negedge clk);
    chk("rs_done", 32'(bus.done), 32'd0);
    chk("rs_crst", 32'(bus.core_rst_n), 32'd0);
    chk("rs_err", 32'(bus.err), 32'd0);
    chk("rs_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic chk_write(input string nm, input logic [31:0] a, input logic [31:0] d);
    chk({nm, "_we"}, 32'(bus.wr_en), 32'd1);
    chk({nm, "_rdy"}, 32'(bus.in_ready), 32'(a == 32'd4 || nm == "t5" || nm == "t6" ? 0 : 1));
    chk({nm, "_addr"}, bus.wr_addr, a);
    chk({nm, "_data"}, bus.wr_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.restart  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(bus.wr_en), 32'd0);
    chk("rst_crst", 32'(bus.core_rst_n), 32'd0);
    rst_n = 1'b1;
    chk("boot_rdy0", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("boot_rdy1", 32'(bus.in_ready), 32'd1);

    // Two-word image, back to back
    wlog.delete();
    send_word(32'h0000_0002, 0, 0, 0, 0);
    send_word(32'h0000_0013, 0, 0, 0, 0);
    @(negedge clk); chk_write("t1w0", 32'h0, 32'h0000_0013);
    send_word(32'h0010_0093, 0, 0, 0, 0);
    @(negedge clk); chk_write("t1w1", 32'h4, 32'h0010_0093);
    chk("t1_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_crst", 32'(bus.core_rst_n), 32'd1);
    chk("t1_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t1_log0", wlog[0][31:0], 32'h0000_0013);
      chk("t1_log1a", wlog[1][63:32], 32'h4);
    end

    // Empty image
    do_restart();
    wlog.delete();
    send_word(32'h0000_0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("t2_nwr", 32'(wlog.size()), 32'd0);

    // Oversized header
    do_restart();
    wlog.delete();
    send_word(32'h0000_0021, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_err", 32'(bus.err), 32'd1);
    chk("t3_rdy", 32'(bus.in_ready), 32'd0);
    chk("t3_crst", 32'(bus.core_rst_n), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    repeat (6) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("t3_err_hold", 32'(bus.err), 32'd1);
    chk("t3_nwr", 32'(wlog.size()), 32'd0);

    // Two-word image with bubbles, including inside words
    do_restart();
    wlog.delete();
    send_word(32'h0000_0002, 0, 3, 5, 1);
    send_word(32'h0000_0013, 2, 0, 4, 1);
    @(negedge clk); chk_write("t4w0", 32'h0, 32'h0000_0013);
    send_word(32'h0010_0093, 5, 0, 0, 3);
    @(negedge clk); chk_write("t4w1", 32'h4, 32'h0010_0093);
    @(negedge clk);
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_nwr", 32'(wlog.size()), 32'd2);

    // Reset in the middle of a word, then a fresh one-word image
    do_restart();
    send_word(32'h0000_0001, 0, 0, 0, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("t5_rst_addr", bus.wr_addr, 32'd0);
    chk("t5_rst_data", bus.wr_data, 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    wlog.delete();
    send_word(32'h0000_0001, 0, 0, 0, 0);
    send_word(32'hDEAD_BEEF, 0, 0, 0, 0);
    @(negedge clk); chk_write("t5", 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_nwr", 32'(wlog.size()), 32'd1);

    // Restart from DONE
    do_restart();
    wlog.delete();
    send_word(32'h0000_0001, 0, 0, 0, 0);
    send_word(32'h1234_5678, 0, 0, 0, 0);
    @(negedge clk); chk_write("t6", 32'h0, 32'h1234_5678);
    @(negedge clk);
    chk("t6_done", 32'(bus.done), 32'd1);
    chk("t6_crst", 32'(bus.core_rst_n), 32'd1);
    chk("t6_nwr", 32'(wlog.size()), 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
